// File: rtl/regfile_ctx_pkg.sv
// Shared state encodings and defaults for the register-file context-switch sequencer.
// PC save/restore states exist only when REGFILE_CTX_PC_EN is defined.
package regfile_ctx_pkg;

   localparam logic [31:0] CTX_BASE_DEFAULT = 32'h0000_1000;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SAVE    = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_LOAD_WB = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
`ifdef REGFILE_CTX_PC_EN
   localparam logic [2:0] S_PC_SAVE = 3'd5;
   localparam logic [2:0] S_PC_LOAD = 3'd6;
   localparam logic [2:0] S_PC_WB   = 3'd7;
`endif

endpackage

// File: rtl/regfile_ctx_addr.sv
// Save-area word address generator: base + pid*NREGS + idx, wrapping modulo 2^32.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module regfile_ctx_addr #(
   parameter int          NREGS = 64,
   parameter int          PID_W = 4,
   parameter int          RW    = 6,
   parameter logic [31:0] BASE  = 32'h0000_1000
) (
   input  logic [PID_W-1:0] pid,
   input  logic [RW-1:0]    idx,
   output logic [31:0]      addr
);

   assign addr = BASE + 32'(pid) * 32'(NREGS) + 32'(idx);

endmodule

// File: rtl/regfile_ctx_switch.sv
// Context-switch sequencer: saves r1..rN-1 of the outgoing pid, reloads the incoming pid (PC too with REGFILE_CTX_PC_EN).
// Latency: 1 cycle per save, 2 per load, +1 done cycle; same-pid switch completes immediately.
// Backpressure: every memory request holds address/data until mem_ack; start is ignored while busy.
module regfile_ctx_switch
   import regfile_ctx_pkg::*;
#(
   parameter int          NREGS    = 64,
   parameter int          DATA_W   = 32,
   parameter int          PID_W    = 4,
   parameter logic [31:0] CTX_BASE = CTX_BASE_DEFAULT,
   localparam int         RW       = $clog2(NREGS)
) (
   input  logic              ck,
   input  logic              rst,
   input  logic              start,
   input  logic              init,
   input  logic [PID_W-1:0]  old_pid,
   input  logic [PID_W-1:0]  new_pid,
`ifdef REGFILE_CTX_PC_EN
   input  logic [31:0]       pc_in,
   output logic [31:0]       pc_out,
   output logic              pc_load,
`endif
   output logic              busy,
   output logic              done,
   output logic [RW-1:0]     rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              rf_we,
   output logic [RW-1:0]     rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

`ifdef REGFILE_CTX_PC_EN
   localparam logic [2:0] FIRST_SAVE = S_PC_SAVE;
   localparam logic [2:0] FIRST_LOAD = S_PC_LOAD;
`else
   localparam logic [2:0] FIRST_SAVE = S_SAVE;
   localparam logic [2:0] FIRST_LOAD = S_LOAD;
`endif

   localparam logic [RW-1:0] IDX_FIRST = RW'(1);
   localparam logic [RW-1:0] IDX_LAST  = RW'(NREGS - 1);

   logic [2:0]        state;
   logic [RW-1:0]     idx;
   logic [PID_W-1:0]  old_q;
   logic [PID_W-1:0]  new_q;
   logic [DATA_W-1:0] ld_data;

   logic [PID_W-1:0]  addr_pid;
   logic [RW-1:0]     addr_idx;
   logic [31:0]       gen_addr;
   logic              last;

   assign last = (idx == IDX_LAST);

   regfile_ctx_addr #(
      .NREGS (NREGS),
      .PID_W (PID_W),
      .RW    (RW),
      .BASE  (CTX_BASE)
   ) u_addr (
      .pid  (addr_pid),
      .idx  (addr_idx),
      .addr (gen_addr)
   );

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= IDX_FIRST;
         old_q   <= '0;
         new_q   <= '0;
         ld_data <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  idx   <= IDX_FIRST;
                  old_q <= old_pid;
                  new_q <= new_pid;
                  if (old_pid == new_pid) state <= S_DONE;
                  else if (init)          state <= FIRST_LOAD;
                  else                    state <= FIRST_SAVE;
               end
            end
            S_SAVE: begin
               if (mem_ack) begin
                  if (last) begin
                     idx   <= IDX_FIRST;
                     state <= FIRST_LOAD;
                  end else begin
                     idx <= idx + RW'(1);
                  end
               end
            end
            S_LOAD: begin
               if (mem_ack) begin
                  ld_data <= mem_rdata;
                  state   <= S_LOAD_WB;
               end
            end
            S_LOAD_WB: begin
               if (last) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + RW'(1);
                  state <= S_LOAD;
               end
            end
            S_DONE: state <= S_IDLE;
`ifdef REGFILE_CTX_PC_EN
            S_PC_SAVE: if (mem_ack) state <= S_SAVE;
            S_PC_LOAD: begin
               if (mem_ack) begin
                  ld_data <= mem_rdata;
                  state   <= S_PC_WB;
               end
            end
            S_PC_WB: state <= S_LOAD;
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef REGFILE_CTX_PC_EN
   always_ff @(posedge ck or posedge rst) begin
      if (rst)                              pc_out <= '0;
      else if (state == S_PC_LOAD && mem_ack) pc_out <= 32'(mem_rdata);
   end

   assign pc_load = (state == S_PC_WB);
`endif

   // Outputs decode from state so they are all zero in IDLE and during reset.
   always_comb begin
      rf_raddr  = '0;
      rf_we     = 1'b0;
      rf_waddr  = '0;
      rf_wdata  = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      addr_pid  = old_q;
      addr_idx  = idx;
      case (state)
         S_SAVE: begin
            rf_raddr  = idx;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = rf_rdata;
         end
         S_LOAD: begin
            mem_req  = 1'b1;
            addr_pid = new_q;
         end
         S_LOAD_WB: begin
            rf_we    = 1'b1;
            rf_waddr = idx;
            rf_wdata = ld_data;
         end
`ifdef REGFILE_CTX_PC_EN
         S_PC_SAVE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = DATA_W'(pc_in);
            addr_idx  = '0;
         end
         S_PC_LOAD: begin
            mem_req  = 1'b1;
            addr_pid = new_q;
            addr_idx = '0;
         end
`endif
         default: ;
      endcase
   end

   assign mem_addr = mem_req ? gen_addr : 32'h0;
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);

endmodule

// File: tb/tb_regfile_ctx_switch.sv
// Scoreboard bench for regfile_ctx_switch: driver queues expected memory/register traffic and done
// latencies, a negedge monitor pops and compares them as the DUT produces them.
module tb_regfile_ctx_switch;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } xact_t;

   logic        ck = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        init = 1'b0;
   logic [3:0]  old_pid = '0;
   logic [3:0]  new_pid = '0;
   logic        busy, done;
   logic [5:0]  rf_raddr, rf_waddr;
   logic [31:0] rf_rdata, rf_wdata;
   logic        rf_we;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   logic [31:0] rf_m [64];
   logic [31:0] mem [logic [31:0]];

   xact_t       exp_mw [$];
   logic [31:0] exp_mr [$];
   xact_t       exp_rw [$];
   int          exp_done [$];

   int n_cmp = 0, n_err = 0;
   int edge_cnt = 0, t0 = 0;
   int done_seen = 0, n_mw = 0, n_mr = 0;
   int ack_max = 0, wait_cnt = 0;
   bit req_seen = 0;
   bit pend_vld = 0;
   logic [31:0] pend_addr, pend_wdata;
   logic        pend_we;

   regfile_ctx_switch dut (
      .ck(ck), .rst(rst), .start(start), .init(init),
      .old_pid(old_pid), .new_pid(new_pid),
      .busy(busy), .done(done),
      .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 ck = ~ck;
   always @(posedge ck) edge_cnt++;

   assign rf_rdata = rf_m[rf_raddr];

   function automatic logic [31:0] mem_get(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic unexp(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got unexpected event want none queued (t=%0t)", nm, $time);
   endtask

   // Memory responder: decides ack for the coming edge and supplies read data.
   always @(posedge ck) begin
      #1;
      if (ack_max == 0) mem_ack = 1'b1;
      else if (mem_req && wait_cnt == 0) mem_ack = 1'b1;
      else begin
         mem_ack = 1'b0;
         if (mem_req && wait_cnt > 0) wait_cnt--;
      end
      mem_rdata = (mem_req && !mem_we) ? mem_get(mem_addr) : 32'h0;
   end

   // Environment commit: memory and register-file model updates.
   always @(negedge ck) begin
      if (!rst && mem_req && mem_ack) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         wait_cnt = (ack_max == 0) ? 0 : int'($urandom_range(0, ack_max));
      end
      if (!rst && rf_we) rf_m[rf_waddr] = rf_wdata;
   end

   // Monitor / scoreboard.
   always @(negedge ck) begin
      xact_t e;
      logic [31:0] a;
      int l;
      if (mem_req) req_seen = 1;
      if (!rst && pend_vld) begin
         chk("hold_req", 32'(mem_req), 32'd1);
         chk("hold_we", 32'(mem_we), 32'(pend_we));
         chk("hold_addr", mem_addr, pend_addr);
         chk("hold_wdata", mem_wdata, pend_wdata);
      end
      pend_vld   = !rst && mem_req && !mem_ack;
      pend_addr  = mem_addr;
      pend_wdata = mem_wdata;
      pend_we    = mem_we;
      if (!rst && mem_req && mem_ack) begin
         if (mem_we) begin
            n_mw++;
            if (exp_mw.size() == 0) unexp("mem_wr");
            else begin
               e = exp_mw.pop_front();
               chk("mw_addr", mem_addr, e.addr);
               chk("mw_data", mem_wdata, e.data);
            end
         end else begin
            n_mr++;
            if (exp_mr.size() == 0) unexp("mem_rd");
            else begin
               a = exp_mr.pop_front();
               chk("mr_addr", mem_addr, a);
            end
         end
      end
      if (!rst && rf_we) begin
         if (exp_rw.size() == 0) unexp("rf_wr");
         else begin
            e = exp_rw.pop_front();
            chk("rw_addr", 32'(rf_waddr), e.addr);
            chk("rw_data", rf_wdata, e.data);
         end
      end
      if (done) begin
         done_seen++;
         if (exp_done.size() == 0) unexp("done");
         else begin
            l = exp_done.pop_front();
            if (l >= 0) chk("done_lat", 32'(edge_cnt - t0), 32'(l));
         end
      end
   end

   task automatic push_switch(input logic [3:0] o, input logic [3:0] n, input bit ini,
                              input logic [31:0] sv_lo, input logic [31:0] sv_hi, input int split,
                              input logic [31:0] ld, input int nrd, input int nwb, input int lat);
      xact_t x;
      if (o != n) begin
         if (!ini)
            for (int i = 1; i < 64; i++) begin
               x.addr = 32'h1000 + 32'(o) * 64 + 32'(i);
               x.data = ((i < split) ? sv_lo : sv_hi) + 32'(i);
               exp_mw.push_back(x);
            end
         for (int i = 1; i <= nrd; i++) exp_mr.push_back(32'h1000 + 32'(n) * 64 + 32'(i));
         for (int i = 1; i <= nwb; i++) begin
            x.addr = 32'(i);
            x.data = ld + 32'(i);
            exp_rw.push_back(x);
         end
      end
      if (lat != -2) exp_done.push_back(lat);
   endtask

   task automatic do_start(input logic [3:0] o, input logic [3:0] n, input bit ini);
      @(negedge ck);
      old_pid = o; new_pid = n; init = ini; start = 1'b1;
      @(posedge ck); #1;
      t0 = edge_cnt; start = 1'b0; init = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic pulse_start(input logic [3:0] o, input logic [3:0] n);
      @(negedge ck);
      old_pid = o; new_pid = n; start = 1'b1;
      @(posedge ck); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int base = done_seen;
      int n = 0;
      while (done_seen == base && n < 3000) begin
         @(posedge ck);
         n++;
      end
      chk(nm, 32'(done_seen != base), 32'd1);
      repeat (2) @(posedge ck);
   endtask

   task automatic chk_queues(input string nm);
      chk({nm, "_mw_left"}, 32'(exp_mw.size()), 32'd0);
      chk({nm, "_mr_left"}, 32'(exp_mr.size()), 32'd0);
      chk({nm, "_rw_left"}, 32'(exp_rw.size()), 32'd0);
      chk({nm, "_done_left"}, 32'(exp_done.size()), 32'd0);
   endtask

   task automatic chk_rf(input string nm, input logic [31:0] base);
      for (int i = 1; i < 64; i++) chk(nm, rf_m[i], base + 32'(i));
   endtask

   task automatic chk_area(input string nm, input logic [3:0] pid, input logic [31:0] base);
      for (int i = 1; i < 64; i++) chk(nm, mem_get(32'h1000 + 32'(pid) * 64 + 32'(i)), base + 32'(i));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int mw0, mr0, d0, n;
      for (int i = 0; i < 64; i++) rf_m[i] = 32'h100 + 32'(i);
      rf_m[0] = 32'hDEAD_0000;
      for (int i = 1; i < 64; i++) begin
         mem[32'h1000 + 5 * 64 + 32'(i)] = 32'hA00 + 32'(i);
         mem[32'h1000 + 3 * 64 + 32'(i)] = 32'hC00 + 32'(i);
         mem[32'h1000 + 6 * 64 + 32'(i)] = 32'hB00 + 32'(i);
      end

      // Reset state
      repeat (2) @(negedge ck);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rf_raddr", 32'(rf_raddr), 32'd0);
      chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge ck);

      // Full switch 2 -> 5, ack tied high
      push_switch(4'd2, 4'd5, 1'b0, 32'h100, 32'h100, 64, 32'hA00, 63, 63, 189);
      do_start(4'd2, 4'd5, 1'b0);
      wait_done("a_done");
      chk_area("a_save", 4'd2, 32'h100);
      chk_rf("a_rf", 32'hA00);
      chk("a_r0", rf_m[0], 32'hDEAD_0000);
      chk_queues("a");

      // First dispatch to pid 3: loads only
      mw0 = n_mw; mr0 = n_mr;
      push_switch(4'd0, 4'd3, 1'b1, 32'h0, 32'h0, 64, 32'hC00, 63, 63, 126);
      do_start(4'd0, 4'd3, 1'b1);
      wait_done("b_done");
      chk("b_writes", 32'(n_mw - mw0), 32'd0);
      chk("b_reads", 32'(n_mr - mr0), 32'd63);
      chk_rf("b_rf", 32'hC00);
      chk_queues("b");

      // Same pid: immediate done, no memory traffic
      req_seen = 0;
      push_switch(4'd7, 4'd7, 1'b0, 32'h0, 32'h0, 64, 32'h0, 0, 0, 0);
      do_start(4'd7, 4'd7, 1'b0);
      wait_done("c_done");
      chk("c_req_seen", 32'(req_seen), 32'd0);
      chk_queues("c");

      // Random ack delays: same result as the zero-delay run
      for (int i = 1; i < 64; i++) rf_m[i] = 32'h100 + 32'(i);
      ack_max = 5;
      wait_cnt = 3;
      push_switch(4'd2, 4'd5, 1'b0, 32'h100, 32'h100, 64, 32'hA00, 63, 63, -1);
      do_start(4'd2, 4'd5, 1'b0);
      wait_done("d_done");
      chk_rf("d_rf", 32'hA00);
      chk_area("d_save", 4'd2, 32'h100);
      chk_queues("d");
      ack_max = 0;
      repeat (2) @(posedge ck);

      // Reset during load of idx 20, then re-issue
      for (int i = 1; i < 64; i++) rf_m[i] = 32'h300 + 32'(i);
      d0 = done_seen;
      push_switch(4'd4, 4'd6, 1'b0, 32'h300, 32'h300, 64, 32'hB00, 20, 19, -2);
      do_start(4'd4, 4'd6, 1'b0);
      n = 0;
      while (!(mem_req && !mem_we && mem_addr == 32'h1000 + 6 * 64 + 20) && n < 1000) begin
         @(negedge ck);
         n++;
      end
      chk("e_reach_idx20", 32'(n < 1000), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("e_busy", 32'(busy), 32'd0);
      chk("e_mem_req", 32'(mem_req), 32'd0);
      chk("e_done", 32'(done), 32'd0);
      repeat (3) @(negedge ck);
      rst = 1'b0;
      repeat (2) @(negedge ck);
      chk("e_no_done", 32'(done_seen - d0), 32'd0);
      chk("e_r19", rf_m[19], 32'hB13);
      chk("e_r20", rf_m[20], 32'h314);
      chk_queues("e");
      push_switch(4'd4, 4'd6, 1'b0, 32'hB00, 32'h300, 20, 32'hB00, 63, 63, 189);
      do_start(4'd4, 4'd6, 1'b0);
      wait_done("e2_done");
      chk_rf("e2_rf", 32'hB00);
      chk_queues("e2");

      // Starts while busy are ignored
      d0 = done_seen;
      push_switch(4'd9, 4'd3, 1'b1, 32'h0, 32'h0, 64, 32'hC00, 63, 63, 126);
      do_start(4'd9, 4'd3, 1'b1);
      repeat (10) @(posedge ck);
      pulse_start(4'd1, 4'd1);
      repeat (30) @(posedge ck);
      pulse_start(4'd8, 4'd9);
      wait_done("f_done");
      repeat (20) @(posedge ck);
      chk("f_done_count", 32'(done_seen - d0), 32'd1);
      chk_rf("f_rf", 32'hC00);
      chk_queues("f");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
